// File: rtl/breakthecode_pkg.sv
// Shared types and sizes for the code-breaking game datapath.
// DIGIT_W is the width of one hex digit, COUNT_W is wide enough for any A/B count.
package breakthecode_pkg;

    localparam int DIGIT_W            = 4;
    localparam int COUNT_W            = 4;
    localparam int NUM_DIGITS_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXACT   = 2'd1,
        PARTIAL = 2'd2,
        DONE    = 2'd3
    } scorer_state_t;

endpackage

// File: rtl/first_match_finder.sv
// Combinational search for the lowest secret position that is still unused
// and holds the given guess digit. The result is returned one-hot so the
// caller can OR it straight into the used mask.
module first_match_finder
    import breakthecode_pkg::*;
#(
    parameter int NUM_DIGITS = NUM_DIGITS_DEFAULT
)
(
    input  logic [DIGIT_W*NUM_DIGITS-1:0] secret,
    input  logic [NUM_DIGITS-1:0]         sused,
    input  logic [DIGIT_W-1:0]            digit,
    output logic                          found,
    output logic [NUM_DIGITS-1:0]         hit
);

    logic [NUM_DIGITS-1:0] cand;

    // Every unused position whose digit equals the searched digit is a candidate
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_cand
            assign cand[gi] = !sused[gi] && (secret[gi*DIGIT_W +: DIGIT_W] == digit);
        end
    endgenerate

    // Isolate the lowest set candidate bit (two's complement trick)
    assign found = |cand;
    assign hit   = cand & (~cand + NUM_DIGITS'(1));

endmodule

// File: rtl/code_scorer.sv
// Scores a guess against the stored secret: one EXACT cycle for positional
// matches, then NUM_DIGITS PARTIAL cycles resolving the remaining digits
// against unused secret positions, then DONE publishes A/B/code_break.
// Optional feature macro: CODE_SCORER_GUESS_CHECK_EN (reject guesses with a
// digit above 9; the rejected guess reports in 3 cycles with A=B=0).
module code_scorer
    import breakthecode_pkg::*;
#(
    parameter int NUM_DIGITS = NUM_DIGITS_DEFAULT
)
(
    input  logic                          clk,
    input  logic                          resetb,
    input  logic                          load_secret,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] secret,
    input  logic                          score_req,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] guess,
    output logic                          busy,
    output logic                          score_valid,
    output logic [COUNT_W-1:0]            correct_code,
    output logic [COUNT_W-1:0]            correct_loc,
    output logic                          code_break,
    output logic                          guess_invalid
);

    localparam int CODE_W = DIGIT_W * NUM_DIGITS;
    localparam int IDX_W  = $clog2(NUM_DIGITS);

    scorer_state_t          state_q, state_d;
    logic [CODE_W-1:0]      secret_q, secret_d;
    logic [CODE_W-1:0]      guess_q, guess_d;
    logic [NUM_DIGITS-1:0]  sused_q, sused_d;
    logic [NUM_DIGITS-1:0]  gused_q, gused_d;
    logic [COUNT_W-1:0]     acc_a_q, acc_a_d;
    logic [COUNT_W-1:0]     acc_b_q, acc_b_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   busy_q, busy_d;
    logic                   score_valid_q, score_valid_d;
    logic [COUNT_W-1:0]     correct_code_q, correct_code_d;
    logic [COUNT_W-1:0]     correct_loc_q, correct_loc_d;
    logic                   code_break_q, code_break_d;

    logic [NUM_DIGITS-1:0]  exact_vec;
    logic [COUNT_W-1:0]     exact_cnt;
    logic [DIGIT_W-1:0]     cur_digit;
    logic                   found;
    logic [NUM_DIGITS-1:0]  hit;
    logic                   take_hit;

    // Positional comparison of guess and secret digits
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_exact
            assign exact_vec[gi] = guess_q[gi*DIGIT_W +: DIGIT_W] == secret_q[gi*DIGIT_W +: DIGIT_W];
        end
    endgenerate

    // Popcount of positional matches, loaded into both accumulators
    always_comb begin
        exact_cnt = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            exact_cnt = exact_cnt + COUNT_W'(exact_vec[i]);
        end
    end

    // Select the guess digit currently being resolved
    always_comb begin
        cur_digit = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_digit = guess_q[i*DIGIT_W +: DIGIT_W];
            end
        end
    end

    first_match_finder #(
        .NUM_DIGITS (NUM_DIGITS)
    ) u_finder (
        .secret (secret_q),
        .sused  (sused_q),
        .digit  (cur_digit),
        .found  (found),
        .hit    (hit)
    );

`ifdef CODE_SCORER_GUESS_CHECK_EN
    logic                   bad_q, bad_d;
    logic                   invalid_q, invalid_d;
    logic [NUM_DIGITS-1:0]  digit_over9;

    // A digit above 9 cannot be shown on the decimal seven-segment path
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_over9
            assign digit_over9[gi] = guess_q[gi*DIGIT_W +: DIGIT_W] > DIGIT_W'(9);
        end
    endgenerate

    assign take_hit      = found && !gused_q[idx_q] && !bad_q;
    assign guess_invalid = invalid_q;
`else
    assign take_hit      = found && !gused_q[idx_q];
    assign guess_invalid = 1'b0;
`endif

    // Next-state and datapath update for the scoring sequence
    always_comb begin
        state_d        = state_q;
        secret_d       = secret_q;
        guess_d        = guess_q;
        sused_d        = sused_q;
        gused_d        = gused_q;
        acc_a_d        = acc_a_q;
        acc_b_d        = acc_b_q;
        idx_d          = idx_q;
        busy_d         = busy_q;
        score_valid_d  = 1'b0;
        correct_code_d = correct_code_q;
        correct_loc_d  = correct_loc_q;
        code_break_d   = code_break_q;
`ifdef CODE_SCORER_GUESS_CHECK_EN
        bad_d          = bad_q;
        invalid_d      = invalid_q;
`endif
        case (state_q)
            IDLE: begin
                // busy stays up through the score_valid cycle; strobes there are dropped
                if (busy_q) begin
                    busy_d = 1'b0;
                end else begin
                    if (load_secret) begin
                        secret_d = secret;
                    end
                    if (score_req) begin
                        guess_d = guess;
                        busy_d  = 1'b1;
                        state_d = EXACT;
                    end
                end
            end
            EXACT: begin
                sused_d = exact_vec;
                gused_d = exact_vec;
                acc_a_d = exact_cnt;
                acc_b_d = exact_cnt;
                idx_d   = '0;
                state_d = PARTIAL;
`ifdef CODE_SCORER_GUESS_CHECK_EN
                // A rejected guess spends a single inert PARTIAL cycle so it reports in 3 cycles
                bad_d = |digit_over9;
                if (|digit_over9) begin
                    idx_d = IDX_W'(NUM_DIGITS - 1);
                end
`endif
            end
            PARTIAL: begin
                if (take_hit) begin
                    sused_d = sused_q | hit;
                    acc_a_d = acc_a_q + COUNT_W'(1);
                end
                if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                correct_code_d = acc_a_q;
                correct_loc_d  = acc_b_q;
                code_break_d   = acc_b_q == COUNT_W'(NUM_DIGITS);
                score_valid_d  = 1'b1;
                state_d        = IDLE;
`ifdef CODE_SCORER_GUESS_CHECK_EN
                invalid_d = bad_q;
                if (bad_q) begin
                    correct_code_d = '0;
                    correct_loc_d  = '0;
                    code_break_d   = 1'b0;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset aborts any scoring pass immediately
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q        <= IDLE;
            secret_q       <= '0;
            guess_q        <= '0;
            sused_q        <= '0;
            gused_q        <= '0;
            acc_a_q        <= '0;
            acc_b_q        <= '0;
            idx_q          <= '0;
            busy_q         <= 1'b0;
            score_valid_q  <= 1'b0;
            correct_code_q <= '0;
            correct_loc_q  <= '0;
            code_break_q   <= 1'b0;
`ifdef CODE_SCORER_GUESS_CHECK_EN
            bad_q          <= 1'b0;
            invalid_q      <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            secret_q       <= secret_d;
            guess_q        <= guess_d;
            sused_q        <= sused_d;
            gused_q        <= gused_d;
            acc_a_q        <= acc_a_d;
            acc_b_q        <= acc_b_d;
            idx_q          <= idx_d;
            busy_q         <= busy_d;
            score_valid_q  <= score_valid_d;
            correct_code_q <= correct_code_d;
            correct_loc_q  <= correct_loc_d;
            code_break_q   <= code_break_d;
`ifdef CODE_SCORER_GUESS_CHECK_EN
            bad_q          <= bad_d;
            invalid_q      <= invalid_d;
`endif
        end
    end

    assign busy         = busy_q;
    assign score_valid  = score_valid_q;
    assign correct_code = correct_code_q;
    assign correct_loc  = correct_loc_q;
    assign code_break   = code_break_q;

endmodule
